// File: rtl/cp0_pkg.sv
// Shared definitions for the CP0 system coprocessor: register indices,
// SR/Cause field positions and reset values.
package cp0_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_SR      = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_PRID    = 5'd15;

    localparam int IM_HI   = 15;
    localparam int IM_LO   = 10;
    localparam int EXL_BIT = 1;
    localparam int IE_BIT  = 0;

    localparam int HW_INT_W = 6;

    localparam logic [5:0]  IM_RST      = 6'd0;
    localparam logic [29:0] EPC_RST     = 30'd0;
    localparam logic [31:0] COUNT_RST   = 32'd0;
    localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/cp0_sync.sv
// N-stage flop synchroniser for the external interrupt lines; every stage
// clears on the asynchronous active-low reset.
module cp0_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    always_comb begin
        stage_d[0] = async_in;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // NOTE: these are individual flops, not a RAM, so each stage gets the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking so every stage samples its predecessor's old value.
            stage_q <= stage_d;
        end
    end

    assign sync_out = stage_q[STAGES-1];

endmodule

// File: rtl/cp0_unit.sv
// System coprocessor 0: SR, Cause, EPC, PRId, Count and Compare, interrupt
// synchronisation and the irq request to the multicycle controller.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID        = 32'h0001_8000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cp0Wr,
    input  logic [4:0]  sel,
    input  logic [31:0] din,
    input  logic [31:0] pc,
    input  logic        EXLSet,
    input  logic        EXLClr,
    input  logic [5:0]  hw_int,
    output logic [31:0] dout,
    output logic [31:0] epc,
    output logic        irq
);

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic [29:0] epc_q, epc_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        tp_q, tp_d;

    logic [HW_INT_W-1:0] hw_sync;
    logic [5:0]          ip;
    logic [31:0]         sr_val;
    logic [31:0]         cause_val;
    logic                wr_sr, wr_epc, wr_count, wr_cmp;
    logic                unused_pc;

    cp0_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (HW_INT_W)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (hw_int),
        .sync_out (hw_sync)
    );

    // The timer shares IP[15] with hw_int[5].
    assign ip = {hw_sync[5] | tp_q, hw_sync[4:0]};

    assign wr_sr    = cp0Wr && (sel == CP0_SR);
    assign wr_epc   = cp0Wr && (sel == CP0_EPC);
    assign wr_count = cp0Wr && (sel == CP0_COUNT);
    assign wr_cmp   = cp0Wr && (sel == CP0_COMPARE);

    // NOTE: every output of this block is defaulted first so no latch can be inferred.
    always_comb begin
        im_d      = im_q;
        ie_d      = ie_q;
        exl_d     = exl_q;
        epc_d     = epc_q;
        compare_d = compare_q;
        tp_d      = tp_q;
        count_d   = count_q + 32'd1;

        if (wr_sr) begin
            im_d  = din[IM_HI:IM_LO];
            ie_d  = din[IE_BIT];
            exl_d = din[EXL_BIT];
        end
        // Controller strobes override software for the EXL bit only.
        if (EXLSet) begin
            exl_d = 1'b1;
        end else if (EXLClr) begin
            exl_d = 1'b0;
        end

        if (EXLSet) begin
            if (!exl_q) begin
                epc_d = pc[31:2];
            end
        end else if (wr_epc) begin
            epc_d = din[31:2];
        end

        if (wr_count) begin
            count_d = din;
        end

        if (wr_cmp) begin
            compare_d = din;
            tp_d      = 1'b0;
        end else if (count_q == compare_q) begin
            tp_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            im_q      <= IM_RST;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            epc_q     <= EPC_RST;
            count_q   <= COUNT_RST;
            compare_q <= COMPARE_RST;
            tp_q      <= 1'b0;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            epc_q     <= epc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            tp_q      <= tp_d;
        end
    end

    always_comb begin
        sr_val                = '0;
        sr_val[IM_HI:IM_LO]   = im_q;
        sr_val[EXL_BIT]       = exl_q;
        sr_val[IE_BIT]        = ie_q;
        cause_val             = '0;
        cause_val[IM_HI:IM_LO] = ip;
    end

    always_comb begin
        case (sel)
            CP0_COUNT:   dout = count_q;
            CP0_COMPARE: dout = compare_q;
            CP0_SR:      dout = sr_val;
            CP0_CAUSE:   dout = cause_val;
            CP0_EPC:     dout = {epc_q, 2'b00};
            CP0_PRID:    dout = PRID;
            default:     dout = '0;
        endcase
    end

    // Pure function of registered state, so it falls with rst_n.
    assign irq = ie_q & ~exl_q & |(im_q & ip);
    assign epc = {epc_q, 2'b00};

    assign unused_pc = ^pc[1:0];

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_cp0_unit;

    localparam int          SYNC_STAGES = 2;
    localparam logic [31:0] PRID        = 32'h0001_8000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cp0Wr;
    logic [4:0]  sel;
    logic [31:0] din;
    logic [31:0] pc;
    logic        EXLSet;
    logic        EXLClr;
    logic [5:0]  hw_int;
    logic [31:0] dout;
    logic [31:0] epc;
    logic        irq;

    int vectors    = 0;
    int miscompares = 0;
    bit checking   = 1'b0;

    cp0_unit #(
        .PRID        (PRID),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cp0Wr  (cp0Wr),
        .sel    (sel),
        .din    (din),
        .pc     (pc),
        .EXLSet (EXLSet),
        .EXLClr (EXLClr),
        .hw_int (hw_int),
        .dout   (dout),
        .epc    (epc),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    // Behavioural model: architectural fields kept as plain integers.
    int unsigned m_im      = 0;
    bit          m_exl     = 0;
    bit          m_ie      = 0;
    int unsigned m_epc     = 0;
    int unsigned m_count   = 0;
    int unsigned m_compare = 32'hFFFF_FFFF;
    bit          m_tp      = 0;
    logic [5:0]  m_hist[$];

    function automatic logic [5:0] m_ip();
        logic [5:0] s;
        s = (m_hist.size() >= SYNC_STAGES) ? m_hist[m_hist.size() - SYNC_STAGES] : 6'd0;
        if (m_tp) s[5] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] s);
        case (s)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return (m_im << 10) | (int'(m_exl) << 1) | int'(m_ie);
            5'd13:   return 32'(m_ip()) << 10;
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_irq();
        return m_ie && !m_exl && ((m_im & 32'(m_ip())) != 0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_im = 0; m_exl = 0; m_ie = 0; m_epc = 0;
            m_count = 0; m_compare = 32'hFFFF_FFFF; m_tp = 0;
            m_hist.delete();
        end else begin
            bit nxt_tp;
            nxt_tp = m_tp;
            if (cp0Wr && sel == 5'd11) nxt_tp = 0;
            else if (m_count == m_compare) nxt_tp = 1;
            if (cp0Wr && sel == 5'd12) begin
                m_im  = (din >> 10) & 32'h3F;
                m_ie  = din[0];
                if (!EXLSet && !EXLClr) m_exl = din[1];
            end
            if (EXLSet) begin
                if (!m_exl) m_epc = pc & 32'hFFFF_FFFC;
                m_exl = 1;
            end else begin
                if (EXLClr) m_exl = 0;
                if (cp0Wr && sel == 5'd14) m_epc = din & 32'hFFFF_FFFC;
            end
            m_count = (cp0Wr && sel == 5'd9) ? din : m_count + 1;
            if (cp0Wr && sel == 5'd11) m_compare = din;
            m_tp = nxt_tp;
            m_hist.push_back(hw_int);
            while (m_hist.size() > SYNC_STAGES) void'(m_hist.pop_front());
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check($sformatf("model_dout_sel%0d", sel), dout, m_read(sel));
            check("model_irq", {31'd0, irq}, {31'd0, m_irq()});
            check("model_epc", epc, m_epc);
        end
    end

    task automatic cyc(input logic wr, input logic [4:0] s, input logic [31:0] d,
                       input logic [31:0] p, input logic es, input logic ec);
        @(posedge clk);
        #2;
        cp0Wr = wr; sel = s; din = d; pc = p; EXLSet = es; EXLClr = ec;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; cp0Wr = 0; sel = 0; din = 0; pc = 0;
        EXLSet = 0; EXLClr = 0; hw_int = 0;
        checking = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Reset values
        cyc(0, 5'd12, 0, 0, 0, 0); check("rst_sr", dout, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        cyc(0, 5'd13, 0, 0, 0, 0); check("rst_cause", dout, 32'h0);
        cyc(0, 5'd14, 0, 0, 0, 0); check("rst_epc", dout, 32'h0);
        cyc(0, 5'd15, 0, 0, 0, 0); check("rst_prid", dout, 32'h0001_8000);
        cyc(0, 5'd11, 0, 0, 0, 0); check("rst_compare", dout, 32'hFFFF_FFFF);

        // Interrupt latency through the synchroniser
        cyc(1, 5'd12, 32'h0000_0401, 0, 0, 0);
        hw_int = 6'h01;
        cyc(0, 5'd13, 0, 0, 0, 0); check("irq_edge1", {31'd0, irq}, 32'd0);
        cyc(0, 5'd13, 0, 0, 0, 0); check("irq_edge2", {31'd0, irq}, 32'd1);
        check("cause_hw0", dout, 32'h0000_0400);
        cyc(1, 5'd12, 32'h0000_0400, 0, 0, 0);
        cyc(0, 5'd12, 0, 0, 0, 0); check("irq_ie0", {31'd0, irq}, 32'd0);
        cyc(1, 5'd12, 32'h0000_0401, 0, 0, 0);
        cyc(0, 5'd12, 0, 0, 0, 0); check("irq_ie1", {31'd0, irq}, 32'd1);

        // Exception entry / nested entry / eret
        cyc(0, 5'd14, 0, 32'h0000_3010, 1, 0);
        cyc(0, 5'd14, 0, 0, 0, 0); check("epc_entry", dout, 32'h0000_3010);
        check("epc_port", epc, 32'h0000_3010);
        check("irq_exl", {31'd0, irq}, 32'd0);
        cyc(0, 5'd12, 0, 0, 0, 0); check("sr_exl", dout, 32'h0000_0403);
        cyc(0, 5'd14, 0, 32'h0000_5000, 1, 0);
        cyc(0, 5'd14, 0, 0, 0, 0); check("epc_nested", dout, 32'h0000_3010);
        cyc(0, 5'd12, 0, 0, 0, 1);
        cyc(0, 5'd12, 0, 0, 0, 0); check("sr_eret", dout, 32'h0000_0401);
        check("irq_eret", {31'd0, irq}, 32'd1);
        hw_int = 6'h00;

        // Timer wrap and match
        cyc(1, 5'd9,  32'hFFFF_FFFE, 0, 0, 0);
        cyc(1, 5'd11, 32'h0000_0001, 0, 0, 0);
        cyc(1, 5'd12, 32'h0000_8001, 0, 0, 0);
        cyc(0, 5'd9, 0, 0, 0, 0); check("count_wrap", dout, 32'h0);
        check("irq_pre_match", {31'd0, irq}, 32'd0);
        cyc(0, 5'd9, 0, 0, 0, 0); check("count_one", dout, 32'h1);
        cyc(0, 5'd13, 0, 0, 0, 0); check("cause_timer", dout, 32'h0000_8000);
        check("irq_timer", {31'd0, irq}, 32'd1);
        cyc(1, 5'd11, 32'h0000_0100, 0, 0, 0); check("irq_cmp_wr_cycle", {31'd0, irq}, 32'd1);
        cyc(0, 5'd13, 0, 0, 0, 0); check("irq_cmp_cleared", {31'd0, irq}, 32'd0);

        // Simultaneous events
        cyc(1, 5'd12, 32'h0000_FC01, 32'h0000_0100, 1, 0);
        cyc(0, 5'd12, 0, 0, 0, 0); check("sr_set_and_wr", dout, 32'h0000_FC03);
        check("epc_set_and_wr", epc, 32'h0000_0100);
        cyc(0, 5'd12, 0, 0, 1, 1);
        cyc(0, 5'd12, 0, 0, 0, 0); check("sr_set_beats_clr", dout, 32'h0000_FC03);

        // Mid-run reset with EXL = 1 and the timer pending
        cyc(1, 5'd9, 32'h0000_00FF, 0, 0, 0);
        cyc(0, 5'd13, 0, 0, 0, 0);
        cyc(0, 5'd13, 0, 0, 0, 0); check("cause_no_tp_yet", dout, 32'h0);
        cyc(0, 5'd13, 0, 0, 0, 0); check("cause_tp_exl", dout, 32'h0000_8000);
        #1 rst_n = 1'b0;
        #1 check("irq_async_rst", {31'd0, irq}, 32'd0);
        check("cause_async_rst", dout, 32'h0);
        check("epc_async_rst", epc, 32'h0);
        @(posedge clk); #2 rst_n = 1'b1;
        cyc(0, 5'd12, 0, 0, 0, 0); check("post_rst_sr", dout, 32'h0);
        cyc(0, 5'd13, 0, 0, 0, 0); check("post_rst_cause", dout, 32'h0);
        cyc(0, 5'd14, 0, 0, 0, 0); check("post_rst_epc", dout, 32'h0);
        cyc(0, 5'd11, 0, 0, 0, 0); check("post_rst_compare", dout, 32'hFFFF_FFFF);

        // Randomized traffic checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            int unsigned pick;
            @(posedge clk);
            #2;
            rst_n = 1'b1;
            cp0Wr = ($urandom_range(0, 99) < 25);
            pick  = $urandom_range(0, 7);
            case (pick)
                0: sel = 5'd9;
                1: sel = 5'd11;
                2: sel = 5'd12;
                3: sel = 5'd13;
                4: sel = 5'd14;
                5: sel = 5'd15;
                default: sel = 5'($urandom_range(0, 31));
            endcase
            din = $urandom;
            if (sel == 5'd11 && $urandom_range(0, 1) == 1) din = m_count + $urandom_range(1, 8);
            if (sel == 5'd9 && $urandom_range(0, 1) == 1) din = m_compare - $urandom_range(0, 8);
            pc     = $urandom;
            EXLSet = ($urandom_range(0, 15) == 0);
            EXLClr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) hw_int = 6'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                #2 rst_n = 1'b0;
                #1 check("irq_async_rand", {31'd0, irq}, 32'd0);
            end
        end

        @(posedge clk); #2;
        rst_n = 1'b1; cp0Wr = 0; EXLSet = 0; EXLClr = 0;
        @(negedge clk);
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- System coprocessor 0: the responder to the multicycle controller's exception/CP0 control outputs (cp0Wr, EXLSet, EXLClr), and the source of its irq input.
- Holds SR, Cause, EPC, PRId, Count and Compare.
- Synchronises six external interrupt lines and runs a free-running timer.
- Serves mfc0 reads and mtc0 writes; instantiated beside the register file in the CPU top.

Parameters:
- PRID, 32'h0001_8000, constant value returned for PRId (reg 15).
- SYNC_STAGES, 2, flop depth of the hw_int synchroniser (minimum 2).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cp0Wr  input  1  mtc0 write strobe, one cycle.
- sel  input  5  CP0 register index (instruction rd field).
- din  input  32  mtc0 write data (GPR rt).
- pc  input  32  current PC; captured into EPC on exception entry.
- EXLSet  input  1  exception entry strobe from controller.
- EXLClr  input  1  eret strobe from controller.
- hw_int  input  6  asynchronous external interrupt requests, level, active-high.
- dout  output  32  mfc0 read data, combinational from sel.
- epc  output  32  EPC value for the eret target, low 2 bits zero.
- irq  output  1  interrupt request to controller.

Behaviour:
- Reset (rst_n low, async) sets:
  - SR.IM = 0, SR.EXL = 0, SR.IE = 0; EPC = 0; Count = 0.
  - Compare = 32'hFFFF_FFFF; timer_pending = 0; all synchroniser flops = 0.
  - Outputs while in reset: irq = 0, epc = 0.
- SR (reg 12): IM = bits [15:10], EXL = bit 1, IE = bit 0; all other bits read 0 and ignore writes.
- Cause (reg 13), read-only:
  - IP[14:10] = synchronised hw_int[4:0].
  - IP[15] = synchronised hw_int[5] OR timer_pending.
  - Other bits read 0.
- EPC (reg 14): bits [31:2] stored, [1:0] read 0. Writable by mtc0.
- Count (reg 9):
  - Increments by 1 every cycle; wraps from FFFF_FFFF to 0.
  - An mtc0 write loads din in that cycle, with no increment that cycle.
- Compare (reg 11):
  - Writable.
  - Any write clears timer_pending.
  - timer_pending is set when Count equals Compare and no Compare write occurs that cycle; the write wins over the match.
- PRId (reg 15) reads PRID. Any other index reads 0; writes to it are ignored.
- irq = SR.IE & ~SR.EXL & |(SR.IM & Cause.IP). Combinational from registered state, so the controller samples it in its interrupt state.
- Latency:
  - hw_int rising → IP bit set after SYNC_STAGES clock edges.
  - irq follows in the same cycle as the IP bit.
- EXLSet:
  - SR.EXL <= 1.
  - EPC <= pc[31:2], only if SR.EXL was 0; nested entry leaves EPC unchanged.
- EXLClr: SR.EXL <= 0.
- Simultaneous events:
  - EXLSet beats EXLClr.
  - Either EXL strobe beats an mtc0 SR write for the EXL bit only; IM and IE take din.
  - EXLSet beats an mtc0 EPC write.
- Read/write in the same cycle: dout shows the pre-write value.
- Mid-operation reset clears everything immediately. irq drops asynchronously with rst_n.

Decomposition:
- Shared package cp0_pkg holds:
  - Register index constants: CP0_COUNT = 9, CP0_COMPARE = 11, CP0_SR = 12, CP0_CAUSE = 13, CP0_EPC = 14, CP0_PRID = 15.
  - SR/Cause bit-position constants: IM/IP hi = 15, lo = 10, EXL = 1, IE = 0.
  - Reset value constants.
- One sub-module, cp0_sync: parameterised N-stage, 6-bit-wide synchroniser with async active-low reset.

Test Plan:
- Reset, then read regs 12/13/14/15/11 → 0, 0, 0, 32'h0001_8000, 32'hFFFF_FFFF; irq = 0.
- mtc0 SR = 32'h0000_0401, then pulse hw_int[0] high → Cause reads 32'h0000_0400 and irq = 1 exactly 2 edges after the rise; with SR = 32'h0000_0400 (IE = 0), irq stays 0.
- irq = 1, pc = 32'h0000_3010, pulse EXLSet → EPC = 32'h0000_3010, SR.EXL = 1, irq = 0. A second EXLSet with pc = 32'h0000_5000 leaves EPC = 32'h0000_3010. EXLClr → EXL = 0 and irq = 1 again.
- Timer: mtc0 Count = 32'hFFFF_FFFE and Compare = 32'h0000_0001, SR = 32'h0000_8001 → Count wraps to 0, then timer_pending and irq assert when Count = 1. Writing Compare = 32'h0000_0100 clears irq the next cycle.
- Same-cycle EXLSet plus mtc0 SR = 32'h0000_FC01 → SR reads 32'h0000_FC03. Same-cycle EXLSet plus EXLClr → EXL = 1.
- Assert rst_n low mid-run with EXL = 1 and timer pending → irq = 0 asynchronously. All registers read reset values after release.
